xnor_match_counter: RTL
=======================

// Module: xnor_match_counter
// PURPOSE
//  Multi-cycle bitwise-similarity unit on the consumer side of the ALU XNOR path.
//  - Latches XNOR(A,B), then counts matching bit positions over several cycles.
//  - Reports the match count, an all-equal flag and the latched XNOR mask.
//  - Used by the datapath for compare/equality flag generation via a start/done handshake.
// PARAMETERS
//  WIDTH           16  operand width in bits; must be a multiple of BITS_PER_CYCLE
//  BITS_PER_CYCLE   4  mask bits popcounted per SCAN cycle
//  CW              $clog2(WIDTH+1) = 5; count width (localparam)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high reset
//  start        in   1      request; accepted only when state==IDLE
//  A            in   WIDTH  operand A, sampled on the accept edge
//  B            in   WIDTH  operand B, sampled on the accept edge
//  busy         out  1      high whenever state!=IDLE (SCAN or DONE)
//  done         out  1      one-cycle pulse; results valid and stable from this cycle
//  match_count  out  CW     number of bit positions where A==B
//  equal        out  1      1 when match_count==WIDTH
//  mask         out  WIDTH  latched ~(A^B), valid from the cycle after accept
// BEHAVIOUR
//  Reset
//  - All of the following are cleared when reset is sampled high:
//    state=IDLE, busy=0, done=0, match_count=0, equal=0, mask=0,
//    internal accumulator=0, internal slice index=0.
//  - Reset wins over start in the same cycle.
//  - Reset in SCAN or DONE aborts the operation: no done pulse, outputs cleared.
//  FSM
//  - IDLE: when start=1 -> mask<=~(A^B), acc<=0, idx<=0; go to SCAN.
//  - SCAN: acc<=acc+popcount(mask[idx*BPC +: BPC]); idx<=idx+1.
//    After WIDTH/BPC SCAN cycles (4 at defaults), go to DONE.
//  - DONE: done=1; match_count<=final acc; equal<=(final acc==WIDTH); go to IDLE.
//  - match_count, equal and mask hold until the next accepted start.
//  - On an accepted start, match_count and equal keep their old values until the
//    next DONE; mask updates immediately.
//  Timing
//  - start accepted at edge k: SCAN during cycles k+1..k+4; done=1 in cycle k+5,
//    with match_count/equal already updated in that cycle.
//  - busy is high in cycles k+1..k+5.
//  - start is ignored in SCAN and DONE, so A/B changes are not seen.
//  - Minimum accept-to-accept spacing is WIDTH/BPC+2 = 6 cycles. With start held
//    high, a new accept occurs in the IDLE cycle after each done.
//  Arithmetic
//  - acc and match_count are CW bits, unsigned; they cannot overflow (max WIDTH).
//  - Slice popcount is BPC bits wide, zero-extended to CW before the add.
// TESTING
//  1 A=B=16'hA5A5, start at edge 0 -> done only in cycle 5, match_count=16, equal=1,
//    mask=16'hFFFF; busy high in cycles 1..5.
//  2 A=16'h0000, B=16'hFFFF -> match_count=0, equal=0, mask=16'h0000.
//  3 A=16'h00FF, B=16'h0F0F -> mask=16'hF00F, match_count=8, equal=0.
//  4 Start A=B=16'h1234, then pulse start in cycle 2 with A=0, B=16'hFFFF -> second
//    request ignored; done in cycle 5 with match_count=16; single done pulse.
//  5 Reset in cycle 3 (mid-SCAN) -> no done; all outputs 0 next cycle; a subsequent
//    start with A=16'hFFFF, B=16'hFFFE completes with match_count=15.
//  6 start held high, operands change every cycle -> accepts at edges 0, 6, 12; each
//    result matches the operands sampled at its own accept edge.

Source files
------------

// File: rtl/xnor_match_counter_if.sv
// xnor_match_counter_if
//   Request/result bundle for the xnor_match_counter similarity unit.
//   Handshake: the requester raises start with A/B valid; the request is taken
//   only on a clock edge where the unit is idle (busy low). A taken request
//   cannot be withdrawn. done pulses for one cycle when match_count/equal carry
//   the result of that request. Results then hold until the next done.
//   Signals:
//     start, A, B          requester -> unit
//     busy, done           unit -> requester, status
//     match_count, equal   unit -> requester, result of the last completed request
//     mask                 unit -> requester, latched ~(A^B) of the last taken request
//     state_dbg            unit -> observer, current FSM state encoding
interface xnor_match_counter_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [CW-1:0]    match_count;
  logic             equal;
  logic [WIDTH-1:0] mask;
  logic [1:0]       state_dbg;

  modport master (
    output start, A, B,
    input  busy, done, match_count, equal, mask, state_dbg
  );

  modport slave (
    input  start, A, B,
    output busy, done, match_count, equal, mask, state_dbg
  );
endinterface

// File: rtl/xnor_match_counter.sv
// xnor_match_counter
//   Multi-cycle bitwise similarity unit. On an accepted start it latches
//   ~(A^B), then popcounts BITS_PER_CYCLE mask bits per cycle and reports the
//   number of matching bit positions, an all-equal flag and the latched mask.
//   Ports:
//     clk     rising-edge clock
//     reset   synchronous, active-high; clears all state and outputs
//     bus     xnor_match_counter_if.slave (start/A/B in; busy/done/match_count/
//             equal/mask/state_dbg out)
//   Timing: start accepted at edge k -> SCAN in cycles k+1..k+NSLICE,
//   done in cycle k+NSLICE+1 with match_count/equal already updated.
module xnor_match_counter #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  xnor_match_counter_if.slave   bus
);
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int BPC    = BITS_PER_CYCLE;
  localparam int NSLICE = WIDTH / BPC;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mask_q;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    acc_sum;
  logic [CW-1:0]    count_q;
  logic             equal_q;
  logic [IW-1:0]    idx;
  logic [BPC-1:0]   slice;
  logic             last_slice;

  // Slice popcount, zero-extended to the accumulator width.
  function automatic logic [CW-1:0] popcount(input logic [BPC-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < BPC; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    slice      = mask_q[int'(idx) * BPC +: BPC];
    acc_sum    = acc + popcount(slice);
    last_slice = (idx == IW'(NSLICE - 1));
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SCAN;
      SCAN:    if (last_slice) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mask_q  <= '0;
      acc     <= '0;
      idx     <= '0;
      count_q <= '0;
      equal_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mask_q <= ~(bus.A ^ bus.B);
            acc    <= '0;
            idx    <= '0;
          end
        end
        SCAN: begin
          acc <= acc_sum;
          idx <= last_slice ? '0 : idx + IW'(1);
          // Results are committed on the edge into DONE so they are already
          // visible in the cycle that done is high.
          if (last_slice) begin
            count_q <= acc_sum;
            equal_q <= (acc_sum == CW'(WIDTH));
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy        = (state != IDLE);
    bus.done        = (state == DONE);
    bus.match_count = count_q;
    bus.equal       = equal_q;
    bus.mask        = mask_q;
    bus.state_dbg   = state;
  end
endmodule
